// File: rtl/clk_patt_detector.sv
// Clock-pattern detector: checks the CKP, CKN and Track lanes for repeated
// 32-sample toggle / 16-sample low iterations inside a bounded window.
module clk_patt_detector #(
  parameter int ITER_PASS  = 16,
  parameter int WIN_CYCLES = 6144
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_ckp,
  input  logic       i_ckn,
  input  logic       i_track,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_lane_ok,
  output logic [1:0] o_dbg_state,
  output logic [5:0] o_dbg_lane_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DETECT = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_TOG  = 2'd1;
  localparam logic [1:0] L_LOW  = 2'd2;

  localparam int              ITW      = $clog2(ITER_PASS + 1);
  localparam logic [ITW-1:0]  ITER_MAX = ITW'(ITER_PASS);
  localparam logic [12:0]     WIN_LAST = 13'(WIN_CYCLES - 1);
  localparam logic [4:0]      TOG_LAST = 5'd31;
  localparam logic [3:0]      LOW_LAST = 4'd15;

  logic [1:0]  state_q, state_d;
  logic [12:0] win_q;
  logic        in_detect, det_entry, det_exit;
  logic [2:0]  smp;

  logic [1:0]     lst_q [3];
  logic [1:0]     lst_d [3];
  logic [4:0]     tog_q [3];
  logic [4:0]     tog_d [3];
  logic [3:0]     low_q [3];
  logic [3:0]     low_d [3];
  logic [ITW-1:0] it_q  [3];
  logic [ITW-1:0] it_d  [3];
  logic [2:0]     pass_q, pass_d;

  assign smp = {i_track, i_ckn, i_ckp};

  // A session ends on enable drop or window end; both at once is one transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_enable) state_d = S_DETECT;
      S_DETECT: if (!i_enable || (win_q == WIN_LAST)) state_d = S_DONE;
      S_DONE:   state_d = i_enable ? S_DETECT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign in_detect = (state_q == S_DETECT);
  assign det_entry = (state_d == S_DETECT) && !in_detect;
  assign det_exit  = in_detect && (state_d == S_DONE);

  // Toggle count parity gives the expected sample: odd count -> expect 0.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      lst_d[l] = L_IDLE;
      tog_d[l] = '0;
      low_d[l] = '0;
      it_d[l]  = it_q[l];
      if (in_detect) begin
        lst_d[l] = lst_q[l];
        tog_d[l] = tog_q[l];
        low_d[l] = low_q[l];
        case (lst_q[l])
          L_IDLE: begin
            if (smp[l]) begin
              lst_d[l] = L_TOG;
              tog_d[l] = 5'd1;
            end
          end
          L_TOG: begin
            if (smp[l] != tog_q[l][0]) begin
              if (tog_q[l] == TOG_LAST) begin
                lst_d[l] = L_LOW;
                tog_d[l] = '0;
                low_d[l] = '0;
              end else begin
                tog_d[l] = tog_q[l] + 5'd1;
              end
            end else begin
              it_d[l] = '0;
              if (smp[l]) begin
                tog_d[l] = 5'd1;
              end else begin
                lst_d[l] = L_IDLE;
                tog_d[l] = '0;
              end
            end
          end
          L_LOW: begin
            if (!smp[l]) begin
              if (low_q[l] == LOW_LAST) begin
                lst_d[l] = L_IDLE;
                low_d[l] = '0;
                if (it_q[l] != ITER_MAX) it_d[l] = it_q[l] + 1'b1;
              end else begin
                low_d[l] = low_q[l] + 4'd1;
              end
            end else begin
              it_d[l]  = '0;
              lst_d[l] = L_TOG;
              tog_d[l] = 5'd1;
              low_d[l] = '0;
            end
          end
          default: lst_d[l] = L_IDLE;
        endcase
      end
      pass_d[l] = pass_q[l] | (it_d[l] == ITER_MAX);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      pass_q    <= '0;
      o_lane_ok <= '0;
      for (int l = 0; l < 3; l++) begin
        lst_q[l] <= L_IDLE;
        tog_q[l] <= '0;
        low_q[l] <= '0;
        it_q[l]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (det_entry) begin
        win_q     <= '0;
        pass_q    <= '0;
        o_lane_ok <= '0;
        for (int l = 0; l < 3; l++) begin
          lst_q[l] <= L_IDLE;
          tog_q[l] <= '0;
          low_q[l] <= '0;
          it_q[l]  <= '0;
        end
      end else begin
        if (in_detect && (win_q != WIN_LAST)) win_q <= win_q + 13'd1;
        pass_q <= pass_d;
        // Capture includes a pass earned by the final DETECT sample.
        if (det_exit) o_lane_ok <= pass_d;
        for (int l = 0; l < 3; l++) begin
          lst_q[l] <= lst_d[l];
          tog_q[l] <= tog_d[l];
          low_q[l] <= low_d[l];
          it_q[l]  <= it_d[l];
        end
      end
    end
  end

  assign o_busy           = in_detect;
  assign o_done           = (state_q == S_DONE);
  assign o_dbg_state      = state_q;
  assign o_dbg_lane_state = {lst_q[2], lst_q[1], lst_q[0]};

endmodule

// File: tb/tb_clk_patt_detector.sv
// Bench for clk_patt_detector: directed vector table, hand-written reset and
// re-entry sequences, and randomized sessions against a prefix-matching model.
module tb_clk_patt_detector;

  localparam int ITER_PASS = 16;
  localparam int WIN       = 6144;
  localparam int PLEN      = 48;

  localparam int K_PERF   = 0;
  localparam int K_STUCK0 = 1;
  localparam int K_GLITCH = 2;
  localparam int K_NOISY  = 3;
  localparam int K_EARLY  = 4;

  typedef struct {
    int         k_ckp;
    int         k_ckn;
    int         k_trk;
    int         drop_at;
    logic [2:0] exp_ok;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst, i_enable, i_ckp, i_ckn, i_track;
  logic       o_busy, o_done;
  logic [2:0] o_lane_ok;
  logic [1:0] o_dbg_state;
  logic [5:0] o_dbg_lane_state;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] exp_q[$];
  vec_t       vecs[9];

  int         kind[3];
  int         off[3];
  int         m_len[3];
  int         m_cnt[3];
  logic [2:0] m_pass;

  clk_patt_detector #(.ITER_PASS(ITER_PASS), .WIN_CYCLES(WIN)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_enable         (i_enable),
    .i_ckp            (i_ckp),
    .i_ckn            (i_ckn),
    .i_track          (i_track),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_lane_ok        (o_lane_ok),
    .o_dbg_state      (o_dbg_state),
    .o_dbg_lane_state (o_dbg_lane_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Golden iteration: 32 alternating samples starting with 1, then 16 zeros.
  function automatic logic gold_bit(input int pos);
    return (pos < 32) ? ((pos % 2) == 0) : 1'b0;
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < 3; l++) begin
      m_len[l] = 0;
      m_cnt[l] = 0;
    end
    m_pass = '0;
  endfunction

  // m_len = length of the golden-pattern prefix matched so far.
  function automatic void model_step(input int l, input logic s);
    if (m_len[l] == 0 && !s) return;
    if (s == gold_bit(m_len[l])) begin
      m_len[l]++;
      if (m_len[l] == PLEN) begin
        m_len[l] = 0;
        if (m_cnt[l] < ITER_PASS) m_cnt[l]++;
        if (m_cnt[l] == ITER_PASS) m_pass[l] = 1'b1;
      end
    end else begin
      m_cnt[l] = 0;
      m_len[l] = s ? 1 : 0;
    end
  endfunction

  // ---------------- stimulus ----------------
  function automatic logic gen(input int l, input int idx);
    int   p, it, pos;
    logic b;
    p   = idx + off[l];
    it  = p / PLEN;
    pos = p % PLEN;
    b   = gold_bit(pos);
    case (kind[l])
      K_STUCK0: b = 1'b0;
      K_GLITCH: if ((it % 10) == 9 && pos == 10) b = ~b;
      K_NOISY:  if ($urandom_range(0, 999) == 0) b = ~b;
      K_EARLY:  if (it == 10 && pos == 46) b = 1'b1;
      default:  ;
    endcase
    return b;
  endfunction

  task automatic drive_lanes(input logic v);
    i_ckp   = v;
    i_ckn   = v;
    i_track = v;
  endtask

  task automatic enter_detect(input string tag);
    i_enable = 1'b1;
    drive_lanes(1'b1);
    @(negedge i_clk);
    check({tag, "_entry_busy"}, o_busy, 1);
    check({tag, "_entry_clear"}, o_lane_ok, 0);
    model_clear();
  endtask

  task automatic run_detect(input int drop_at, input int max_n,
                            output int done_idx, output int busy_n);
    done_idx = -1;
    busy_n   = 0;
    for (int idx = 0; idx < max_n; idx++) begin
      logic       en;
      logic [2:0] s;
      en = !(drop_at >= 0 && idx >= drop_at);
      if (o_busy && !o_done) busy_n++;
      for (int l = 0; l < 3; l++) begin
        s[l] = gen(l, idx);
        model_step(l, s[l]);
      end
      i_enable = en;
      i_ckp    = s[0];
      i_ckn    = s[1];
      i_track  = s[2];
      @(negedge i_clk);
      if (o_done) begin
        done_idx = idx;
        break;
      end
    end
  endtask

  task automatic session(input string tag, input int drop_at,
                         input logic [2:0] exp_ok, input bit use_model);
    int         done_idx, busy_n, exp_end;
    logic [2:0] want;
    exp_end = (drop_at >= 0) ? drop_at : WIN - 1;
    if (!use_model) exp_q.push_back(exp_ok);
    enter_detect(tag);
    run_detect(drop_at, WIN, done_idx, busy_n);
    if (use_model) exp_q.push_back(m_pass);
    want = exp_q.pop_front();
    check({tag, "_done_cycle"}, done_idx, exp_end);
    check({tag, "_busy_cycles"}, busy_n, exp_end + 1);
    check({tag, "_lane_ok"}, o_lane_ok, want);
    check({tag, "_done_not_busy"}, o_busy, 0);
    if (drop_at >= 0) begin
      @(negedge i_clk);
      check({tag, "_idle_done_low"}, o_done, 0);
      check({tag, "_idle_hold"}, o_lane_ok, want);
    end else begin
      // Enable still high: DONE goes straight back into a fresh DETECT.
      @(negedge i_clk);
      check({tag, "_reentry_busy"}, o_busy, 1);
      check({tag, "_reentry_clear"}, o_lane_ok, 0);
      i_enable = 1'b0;
      drive_lanes(1'b0);
      @(negedge i_clk);
      check({tag, "_short_done"}, o_done, 1);
      check({tag, "_short_lane_ok"}, o_lane_ok, 0);
      @(negedge i_clk);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int done_idx, busy_n, done_seen;

    i_rst    = 1'b1;
    i_enable = 1'b0;
    drive_lanes(1'b0);

    vecs[0] = '{K_PERF,   K_PERF,   K_PERF,   -1,   3'b111};
    vecs[1] = '{K_PERF,   K_STUCK0, K_PERF,   -1,   3'b101};
    vecs[2] = '{K_GLITCH, K_PERF,   K_PERF,   -1,   3'b110};
    vecs[3] = '{K_PERF,   K_PERF,   K_PERF,   768,  3'b111};
    vecs[4] = '{K_PERF,   K_PERF,   K_PERF,   767,  3'b111};
    vecs[5] = '{K_PERF,   K_PERF,   K_PERF,   766,  3'b000};
    vecs[6] = '{K_PERF,   K_PERF,   K_EARLY,  1343, 3'b111};
    vecs[7] = '{K_PERF,   K_PERF,   K_EARLY,  1342, 3'b011};
    vecs[8] = '{K_STUCK0, K_STUCK0, K_STUCK0, 50,   3'b000};

    repeat (3) @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_lane_ok", o_lane_ok, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_busy", o_busy, 0);

    for (int v = 0; v < 9; v++) begin
      kind[0] = vecs[v].k_ckp;
      kind[1] = vecs[v].k_ckn;
      kind[2] = vecs[v].k_trk;
      for (int l = 0; l < 3; l++) off[l] = 0;
      session($sformatf("vec%0d", v), vecs[v].drop_at, vecs[v].exp_ok, 1'b0);
    end

    // Reset asserted 3000 cycles into DETECT aborts without a done pulse.
    for (int l = 0; l < 3; l++) begin
      kind[l] = K_PERF;
      off[l]  = 0;
    end
    enter_detect("rst_mid");
    run_detect(-1, 3000, done_idx, busy_n);
    check("rst_mid_no_early_done", done_idx, -1);
    check("rst_mid_busy_cycles", busy_n, 3000);
    i_rst = 1'b1;
    #1;
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_done", o_done, 0);
    check("rst_mid_lane_ok", o_lane_ok, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_done || o_busy) done_seen++;
    end
    check("rst_mid_held_quiet", done_seen, 0);
    i_rst = 1'b0;
    session("post_rst", 800, 3'b111, 1'b0);

    // Randomized sessions checked against the model.
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 3; l++) begin
        case ($urandom_range(0, 4))
          0:       kind[l] = K_PERF;
          1:       kind[l] = K_STUCK0;
          2:       kind[l] = K_GLITCH;
          default: kind[l] = K_NOISY;
        endcase
        off[l] = $urandom_range(0, PLEN - 1);
      end
      session($sformatf("rand%0d", r), $urandom_range(700, 2000), 3'b000, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
